arm_test_sequencer: RTL and testbench

- Synthesizable run controller for the ARM pipeline core. It replaces the fixed free-running benches, one per forwarding mode, with a single parametrised sequencer.
- For each of NUM_MODES configurations it holds the core in reset, drives forward_en per mode, runs the core for a bounded number of cycles (or until the core halts), and captures the cycle count.
- Sits beside the ARM instance, in benches and in the FPGA wrapper. Drives the core's rst and forward_en.

---
 rtl/arm_tb_pkg.sv | 31 +++
 rtl/arm_cycle_counter.sv | 57 +++++
 rtl/arm_test_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_arm_test_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_tb_pkg.sv
// ---------------------------------------------------------------------------
// arm_tb_pkg
// Shared definitions for the ARM core run sequencer: the sequencer state
// encoding, default run/reset lengths, the default forwarding mask for the
// classic "no forwarding, then forwarding" pair of runs, and a helper that
// sizes the mode index.
// ---------------------------------------------------------------------------
package arm_tb_pkg;

    // Sequencer states, in the order a normal sequence visits them
    typedef enum logic [2:0] {
        IDLE,
        RESET,
        RUN,
        NEXT,
        DONE
    } seq_state_e;

    localparam int DEF_RUN_CYCLES = 1000;
    localparam int DEF_RST_CYCLES = 2;
    localparam int DEF_CNT_W      = 16;

    // Bit m is forward_en for mode m: mode 0 without forwarding, mode 1 with
    localparam logic [1:0] FWD_PAIR_MASK = 2'b10;

    // A single mode still needs a one-bit index
    function automatic int mode_width(input int numModes);
        return (numModes > 1) ? $clog2(numModes) : 1;
    endfunction

endpackage

// File: rtl/arm_cycle_counter.sv
// ---------------------------------------------------------------------------
// arm_cycle_counter
// Loadable, clearable up-counter with a terminal-value compare.
//
// Ports:
//   clk_i       : clock, rising edge
//   rst_ni      : asynchronous active-low reset (counter goes to 0)
//   clr_i       : synchronous clear (highest priority)
//   load_i      : synchronous load of load_val_i
//   load_val_i  : value loaded by load_i
//   inc_i       : increment by one (lowest priority)
//   term_val_i  : value compared against the current count
//   count_o     : current count
//   term_o      : high while count_o equals term_val_i
// ---------------------------------------------------------------------------
module arm_cycle_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] term_val_i,
    output logic [CNT_W-1:0] count_o,
    output logic             term_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins over load, load wins over increment
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (inc_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign term_o  = (count_q == term_val_i);

endmodule

// File: rtl/arm_test_sequencer.sv
// ---------------------------------------------------------------------------
// arm_test_sequencer
// Run controller for the ARM pipeline core. For each of NUM_MODES
// configurations it holds the core in reset for RST_CYCLES cycles with the
// mode's forward_en applied, lets it run for up to RUN_CYCLES cycles (or
// until the core raises halt), and reports the executed cycle count.
//
// Ports:
//   clk        : clock, all state on the rising edge
//   rst        : asynchronous active-low reset
//   start      : begin a full sequence (only honoured when not busy)
//   halt       : core reached program end (only honoured while running)
//   dut_rst    : active-high reset to the core (low only while running)
//   forward_en : forwarding enable for the current mode
//   mode_idx   : current mode number
//   busy       : a sequence is in progress
//   mode_done  : one-cycle pulse after each mode's run ends
//   run_count  : cycles executed by the last completed mode
//   halted     : last completed mode ended on halt rather than timeout
//   done       : sticky, every mode has completed
// ---------------------------------------------------------------------------
module arm_test_sequencer
    import arm_tb_pkg::*;
#(
    parameter int                   NUM_MODES     = 2,
    parameter logic [NUM_MODES-1:0] MODE_FWD_MASK = FWD_PAIR_MASK,
    parameter int                   RST_CYCLES    = DEF_RST_CYCLES,
    parameter int                   RUN_CYCLES    = DEF_RUN_CYCLES,
    parameter int                   CNT_W         = DEF_CNT_W,
    parameter int                   MODE_W        = mode_width(NUM_MODES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt,
    output logic              dut_rst,
    output logic              forward_en,
    output logic [MODE_W-1:0] mode_idx,
    output logic              busy,
    output logic              mode_done,
    output logic [CNT_W-1:0]  run_count,
    output logic              halted,
    output logic              done
);

    localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);
    // The reset counter starts at 0 on entry, so its last cycle shows RST_CYCLES-1
    localparam logic [CNT_W-1:0]  RST_TERM  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  RUN_TERM  = CNT_W'(RUN_CYCLES);
    localparam logic [CNT_W-1:0]  RUN_FIRST = CNT_W'(1);

    seq_state_e        state_q;
    logic [MODE_W-1:0] modeIdx_q;
    logic [MODE_W-1:0] modeNext;
    logic              dutRst_q;
    logic              forwardEn_q;
    logic              busy_q;
    logic              modeDone_q;
    logic [CNT_W-1:0]  runCount_q;
    logic              halted_q;
    logic              done_q;

    logic [CNT_W-1:0]  rstCnt;
    logic [CNT_W-1:0]  runCnt;
    logic              rstTerm;
    logic              runTerm;
    logic              runExit;
    logic              rstCntClr;
    logic              rstCntInc;
    logic              runCntClr;
    logic              runCntLoad;
    logic              runCntInc;
    logic              unusedRstCnt;

    // Counter steering. The reset counter sits at 0 outside RESET and counts
    // through it. The run counter is preloaded to 1 during RESET so the first
    // RUN cycle already reads 1, and it freezes on the exit cycle so the value
    // latched into run_count includes that cycle.
    always_comb begin
        runExit    = (state_q == RUN) && (halt || runTerm);
        rstCntClr  = (state_q != RESET);
        rstCntInc  = (state_q == RESET);
        runCntLoad = (state_q == RESET);
        runCntClr  = (state_q != RESET) && (state_q != RUN);
        runCntInc  = (state_q == RUN) && !runExit;
    end

    assign modeNext = modeIdx_q + 1'b1;

    arm_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_rst_counter (
        .clk_i      (clk),
        .rst_ni     (rst),
        .clr_i      (rstCntClr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .inc_i      (rstCntInc),
        .term_val_i (RST_TERM),
        .count_o    (rstCnt),
        .term_o     (rstTerm)
    );

    arm_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_run_counter (
        .clk_i      (clk),
        .rst_ni     (rst),
        .clr_i      (runCntClr),
        .load_i     (runCntLoad),
        .load_val_i (RUN_FIRST),
        .inc_i      (runCntInc),
        .term_val_i (RUN_TERM),
        .count_o    (runCnt),
        .term_o     (runTerm)
    );

    // Only the terminal flag of the reset counter matters here
    assign unusedRstCnt = ^rstCnt;

    // Sequencer FSM. Every output is a register loaded on the transition into
    // the state it belongs to, so the core sees clean, glitch-free controls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            modeIdx_q   <= '0;
            dutRst_q    <= 1'b1;
            forwardEn_q <= MODE_FWD_MASK[0];
            busy_q      <= 1'b0;
            modeDone_q  <= 1'b0;
            runCount_q  <= '0;
            halted_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            modeDone_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    dutRst_q <= 1'b1;
                    if (start) begin
                        state_q     <= RESET;
                        modeIdx_q   <= '0;
                        forwardEn_q <= MODE_FWD_MASK[0];
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                    end
                end
                RESET: begin
                    if (rstTerm) begin
                        state_q  <= RUN;
                        dutRst_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (runExit) begin
                        state_q    <= NEXT;
                        dutRst_q   <= 1'b1;
                        modeDone_q <= 1'b1;
                        runCount_q <= runCnt;
                        halted_q   <= halt;
                    end
                end
                NEXT: begin
                    if (modeIdx_q == LAST_MODE) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q     <= RESET;
                        modeIdx_q   <= modeNext;
                        forwardEn_q <= MODE_FWD_MASK[modeNext];
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    dutRst_q <= 1'b1;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign dut_rst    = dutRst_q;
    assign forward_en = forwardEn_q;
    assign mode_idx   = modeIdx_q;
    assign busy       = busy_q;
    assign mode_done  = modeDone_q;
    assign run_count  = runCount_q;
    assign halted     = halted_q;
    assign done       = done_q;

endmodule

// File: tb/tb_arm_test_sequencer.sv
// ---------------------------------------------------------------------------
// tb_arm_test_sequencer
// Directed bench for arm_test_sequencer. Instance A uses the default two-mode
// setup; instance B runs four modes of ten cycles with mask 4'b0101.
// ---------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_arm_test_sequencer;

    logic        clk;
    logic        rstN;
    logic        startA;
    logic        startB;
    logic        haltSig;
    logic        sel;

    logic        dutRstA, fwdA, busyA, modeDoneA, haltedA, doneA;
    logic        modeA;
    logic [15:0] runCountA;
    logic        dutRstB, fwdB, busyB, modeDoneB, haltedB, doneB;
    logic [1:0]  modeB;
    logic [15:0] runCountB;

    logic        oDutRst, oFwd, oBusy, oModeDone, oHalted, oDone;
    logic [1:0]  oModeIdx;
    logic [15:0] oRunCount;

    int checks = 0;
    int errors = 0;

    int obsNextAt[4];
    int obsRunCount[4];
    int obsHalted[4];
    int obsFwd[4];
    int obsFwdChanged[4];
    int obsRunLen[4];
    int obsRstLen[4];
    int obsFirstRun[4];
    int obsModeBad[4];
    int obsDoneAt;
    int obsK1;
    int obsTimeout;

    arm_test_sequencer dutA (
        .clk        (clk),
        .rst        (rstN),
        .start      (startA),
        .halt       (haltSig),
        .dut_rst    (dutRstA),
        .forward_en (fwdA),
        .mode_idx   (modeA),
        .busy       (busyA),
        .mode_done  (modeDoneA),
        .run_count  (runCountA),
        .halted     (haltedA),
        .done       (doneA)
    );

    arm_test_sequencer #(
        .NUM_MODES     (4),
        .MODE_FWD_MASK (4'b0101),
        .RUN_CYCLES    (10)
    ) dutB (
        .clk        (clk),
        .rst        (rstN),
        .start      (startB),
        .halt       (haltSig),
        .dut_rst    (dutRstB),
        .forward_en (fwdB),
        .mode_idx   (modeB),
        .busy       (busyB),
        .mode_done  (modeDoneB),
        .run_count  (runCountB),
        .halted     (haltedB),
        .done       (doneB)
    );

    // Observation mux so one recorder can watch either instance
    assign oDutRst   = sel ? dutRstB   : dutRstA;
    assign oFwd      = sel ? fwdB      : fwdA;
    assign oBusy     = sel ? busyB     : busyA;
    assign oModeDone = sel ? modeDoneB : modeDoneA;
    assign oHalted   = sel ? haltedB   : haltedA;
    assign oDone     = sel ? doneB     : doneA;
    assign oModeIdx  = sel ? modeB     : {1'b0, modeA};
    assign oRunCount = sel ? runCountB : runCountA;

    // Free-running clock, 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts a sequence on the selected instance and records, per mode, what
    // was seen at each falling edge. Cycle k=1 is the first cycle after start
    // was sampled. halt is raised during the given RUN cycle of mode 0/1 and
    // held for three sampled edges so it also spans NEXT and the first RESET
    // cycle. A start pulse can be injected in a chosen RUN cycle of mode 0.
    task automatic applyStimulus(input bit useB, input int halt0, input int halt1,
                                 input int glitchRun);
        int m;
        int runCnt;
        int holdLeft;
        for (int i = 0; i < 4; i++) begin
            obsNextAt[i]     = -1;
            obsRunCount[i]   = -1;
            obsHalted[i]     = -1;
            obsFwd[i]        = -1;
            obsFwdChanged[i] = 0;
            obsRunLen[i]     = 0;
            obsRstLen[i]     = 0;
            obsFirstRun[i]   = -1;
            obsModeBad[i]    = 0;
        end
        obsDoneAt  = -1;
        obsK1      = -1;
        obsTimeout = 1;
        m          = 0;
        runCnt     = 0;
        holdLeft   = 0;
        sel        = useB;
        @(negedge clk);
        if (useB) startB = 1'b1;
        else      startA = 1'b1;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            startA = 1'b0;
            startB = 1'b0;
            if (holdLeft > 0) begin
                holdLeft--;
                if (holdLeft == 0) haltSig = 1'b0;
            end
            if (k == 1) obsK1 = int'({oDone, oBusy, oDutRst, oModeIdx});
            if (oDone) begin
                obsDoneAt  = k;
                obsTimeout = 0;
                break;
            end
            if (m < 4) begin
                if (oBusy && (int'(oModeIdx) != m)) obsModeBad[m]++;
                if (oModeDone) begin
                    obsNextAt[m]   = k;
                    obsRunCount[m] = int'(oRunCount);
                    obsHalted[m]   = int'(oHalted);
                    m++;
                    runCnt = 0;
                end else if (oBusy && oDutRst) begin
                    if (obsRstLen[m] == 0) obsFwd[m] = int'(oFwd);
                    else if (int'(oFwd) != obsFwd[m]) obsFwdChanged[m] = 1;
                    obsRstLen[m]++;
                end else if (!oDutRst) begin
                    runCnt++;
                    obsRunLen[m]++;
                    if (runCnt == 1) obsFirstRun[m] = k;
                    if (int'(oFwd) != obsFwd[m]) obsFwdChanged[m] = 1;
                    if ((m == 0 && halt0 == runCnt) || (m == 1 && halt1 == runCnt)) begin
                        haltSig  = 1'b1;
                        holdLeft = 3;
                    end
                    if (m == 0 && glitchRun == runCnt) begin
                        if (useB) startB = 1'b1;
                        else      startA = 1'b1;
                    end
                end
            end
        end
        haltSig = 1'b0;
        startA  = 1'b0;
        startB  = 1'b0;
    endtask

    // Asynchronous reset values, then a few idle cycles with start low
    task automatic test_reset;
        rstN = 1'b1; startA = 1'b0; startB = 1'b0; haltSig = 1'b0; sel = 1'b0;
        #1 rstN = 1'b0;
        #2;
        checks++;
        if ({dutRstA, fwdA, modeA, busyA, modeDoneA, haltedA, doneA} !== 7'b1000000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl_A: got %b expected 1000000",
                     {dutRstA, fwdA, modeA, busyA, modeDoneA, haltedA, doneA});
        end
        checks++;
        if (runCountA !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_run_count_A: got %0d expected 0", runCountA);
        end
        checks++;
        if ({dutRstB, fwdB, modeB, busyB, doneB} !== 6'b110000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl_B: got %b expected 110000",
                     {dutRstB, fwdB, modeB, busyB, doneB});
        end
        @(negedge clk);
        rstN = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({busyA, dutRstA, doneA} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL idle_hold: got %b expected 010", {busyA, dutRstA, doneA});
        end
    endtask

    // Two full timeout runs; a start pulse in RUN of mode 0 must be ignored
    task automatic test_full_sequence;
        int expNext[2];
        int expFirst[2];
        int expFwd[2];
        expNext  = '{1003, 2006};
        expFirst = '{3, 1006};
        expFwd   = '{0, 1};
        applyStimulus(1'b0, 0, 0, 500);
        checks++;
        if (obsTimeout != 0 || obsDoneAt != 2007) begin
            errors++;
            $display("[TB] FAIL full_done_at: got %0d (timeout %0d) expected 2007", obsDoneAt, obsTimeout);
        end
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obsNextAt[m] != expNext[m] || obsFirstRun[m] != expFirst[m]) begin
                errors++;
                $display("[TB] FAIL full_timing[%0d]: got next %0d first %0d expected %0d %0d",
                         m, obsNextAt[m], obsFirstRun[m], expNext[m], expFirst[m]);
            end
            checks++;
            if (obsRunCount[m] != 1000 || obsHalted[m] != 0) begin
                errors++;
                $display("[TB] FAIL full_result[%0d]: got count %0d halted %0d expected 1000 0",
                         m, obsRunCount[m], obsHalted[m]);
            end
            checks++;
            if (obsFwd[m] != expFwd[m] || obsFwdChanged[m] != 0) begin
                errors++;
                $display("[TB] FAIL full_fwd[%0d]: got %0d changed %0d expected %0d 0",
                         m, obsFwd[m], obsFwdChanged[m], expFwd[m]);
            end
            checks++;
            if (obsRstLen[m] != 2 || obsRunLen[m] != 1000 || obsModeBad[m] != 0) begin
                errors++;
                $display("[TB] FAIL full_phases[%0d]: got rst %0d run %0d modebad %0d expected 2 1000 0",
                         m, obsRstLen[m], obsRunLen[m], obsModeBad[m]);
            end
        end
    endtask

    // Restart from DONE: done clears at once and the rerun matches the first
    task automatic test_rerun_from_done;
        checks++;
        if (doneA !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rerun_pre_done: got %b expected 1", doneA);
        end
        applyStimulus(1'b0, 0, 0, 0);
        checks++;
        if (obsK1 != 12) begin
            errors++;
            $display("[TB] FAIL rerun_first_cycle: got %0d expected 12", obsK1);
        end
        checks++;
        if (obsTimeout != 0 || obsDoneAt != 2007) begin
            errors++;
            $display("[TB] FAIL rerun_done_at: got %0d (timeout %0d) expected 2007", obsDoneAt, obsTimeout);
        end
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obsRunCount[m] != 1000 || obsHalted[m] != 0 || obsNextAt[m] != 1003 + 1003 * m) begin
                errors++;
                $display("[TB] FAIL rerun_result[%0d]: got count %0d halted %0d next %0d expected 1000 0 %0d",
                         m, obsRunCount[m], obsHalted[m], obsNextAt[m], 1003 + 1003 * m);
            end
        end
    endtask

    // Halt in RUN cycle 37 of mode 0, and together with the limit in mode 1
    task automatic test_halt;
        applyStimulus(1'b0, 37, 1000, 0);
        checks++;
        if (obsRunCount[0] != 37 || obsHalted[0] != 1 || obsNextAt[0] != 40) begin
            errors++;
            $display("[TB] FAIL halt_early: got count %0d halted %0d next %0d expected 37 1 40",
                     obsRunCount[0], obsHalted[0], obsNextAt[0]);
        end
        checks++;
        if (obsRstLen[1] != 2 || obsFirstRun[1] != 43 || obsFwd[1] != 1) begin
            errors++;
            $display("[TB] FAIL halt_ignored_in_reset: got rst %0d first %0d fwd %0d expected 2 43 1",
                     obsRstLen[1], obsFirstRun[1], obsFwd[1]);
        end
        checks++;
        if (obsRunCount[1] != 1000 || obsHalted[1] != 1 || obsNextAt[1] != 1043) begin
            errors++;
            $display("[TB] FAIL halt_at_limit: got count %0d halted %0d next %0d expected 1000 1 1043",
                     obsRunCount[1], obsHalted[1], obsNextAt[1]);
        end
        checks++;
        if (obsTimeout != 0 || obsDoneAt != 1044) begin
            errors++;
            $display("[TB] FAIL halt_done_at: got %0d (timeout %0d) expected 1044", obsDoneAt, obsTimeout);
        end
    endtask

    // Short rst pulse in the middle of mode 1 RUN, then stay idle
    task automatic test_async_reset;
        sel    = 1'b0;
        startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        repeat (1105) @(negedge clk);
        checks++;
        if ({dutRstA, modeA, fwdA} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL async_pre_run: got %b expected 011", {dutRstA, modeA, fwdA});
        end
        #2 rstN = 1'b0;
        #0.5;
        checks++;
        if ({dutRstA, modeA, fwdA, busyA, modeDoneA, haltedA, doneA} !== 7'b1000000) begin
            errors++;
            $display("[TB] FAIL async_ctrl: got %b expected 1000000",
                     {dutRstA, modeA, fwdA, busyA, modeDoneA, haltedA, doneA});
        end
        checks++;
        if (runCountA !== 16'd0) begin
            errors++;
            $display("[TB] FAIL async_run_count: got %0d expected 0", runCountA);
        end
        #0.5 rstN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({busyA, dutRstA, modeA, doneA, modeDoneA} !== 5'b01000) begin
                errors++;
                $display("[TB] FAIL async_stays_idle[%0d]: got %b expected 01000",
                         i, {busyA, dutRstA, modeA, doneA, modeDoneA});
            end
        end
    endtask

    // Four ten-cycle modes, forward_en 1,0,1,0, pulses 13 cycles apart
    task automatic test_four_modes;
        int expFwd[4];
        expFwd = '{1, 0, 1, 0};
        applyStimulus(1'b1, 0, 0, 0);
        checks++;
        if (obsTimeout != 0 || obsDoneAt != 53) begin
            errors++;
            $display("[TB] FAIL four_done_at: got %0d (timeout %0d) expected 53", obsDoneAt, obsTimeout);
        end
        for (int m = 0; m < 4; m++) begin
            checks++;
            if (obsNextAt[m] != 13 + 13 * m || obsRunCount[m] != 10 || obsHalted[m] != 0) begin
                errors++;
                $display("[TB] FAIL four_result[%0d]: got next %0d count %0d halted %0d expected %0d 10 0",
                         m, obsNextAt[m], obsRunCount[m], obsHalted[m], 13 + 13 * m);
            end
            checks++;
            if (obsFwd[m] != expFwd[m] || obsFwdChanged[m] != 0 || obsModeBad[m] != 0 ||
                obsRstLen[m] != 2) begin
                errors++;
                $display("[TB] FAIL four_mode_ctrl[%0d]: got fwd %0d changed %0d modebad %0d rst %0d expected %0d 0 0 2",
                         m, obsFwd[m], obsFwdChanged[m], obsModeBad[m], obsRstLen[m], expFwd[m]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_full_sequence;
        test_rerun_from_done;
        test_halt;
        test_async_reset;
        test_four_modes;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
